fetch_unit: RTL

// - Instruction fetch stage feeding decode: owns the PC and issues word requests to instruction memory.
// - Buffers returned instruction words in a small FIFO and presents {opcode, pc} to decode over valid/ready.
// - Accepts redirects (branch/jump) from execute: flushes buffered and in-flight words, then restarts at the new PC.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_e;

    localparam int unsigned INSN_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int unsigned PC_STEP  = 4;

    function automatic logic is_nop(input logic [INSN_W-1:0] insn);
        return insn == NOP_INSN;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO with synchronous flush; the head entry is read straight from storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests under a credit cap, tags returns with their
// address and queues them for decode; redirects discard buffered and in-flight words.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int unsigned  DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [N-1:0]      imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [N-1:0]      redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INSN_W-1:0] dec_opcode,
    output logic [N-1:0]      dec_pc
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    fetch_state_e        state;
    logic [N-1:0]        pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       outstanding_nx;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       drop_nx;
    logic [CW-1:0]       buf_count;
    logic [CW-1:0]       tag_count;
    logic                buf_full;
    logic                buf_empty;
    logic                tag_full;
    logic                tag_empty;
    logic [N-1:0]        tag_head;
    logic [INSN_W+N-1:0] buf_head;
    logic                req_fire;
    logic                rsp_take;
    logic                rsp_push;
    logic                dec_pop;
    logic [N-1:0]        redirect_tgt;

    assign imem_req_valid = (state == RUN) && (({1'b0, outstanding} + {1'b0, buf_count}) < CAP);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_take       = imem_rsp_valid & (outstanding != '0);
    // A word is stale while a flush is draining and also when it lands in a redirect cycle.
    assign rsp_push       = rsp_take & (drop_cnt == '0) & ~redirect_valid;
    assign dec_valid      = ~buf_empty;
    assign dec_pop        = dec_valid & dec_ready;
    assign dec_opcode     = buf_head[INSN_W-1:0];
    assign dec_pc         = buf_head[INSN_W +: N];
    assign redirect_tgt   = redirect_pc & ~N'(3);

    always_comb begin
        outstanding_nx = outstanding;
        if (req_fire && !rsp_take) begin
            outstanding_nx = outstanding + CW'(1);
        end else if (!req_fire && rsp_take) begin
            outstanding_nx = outstanding - CW'(1);
        end
        drop_nx = drop_cnt;
        if (rsp_take && (drop_cnt != '0)) begin
            drop_nx = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nx;
            case (state)
                BOOT: begin
                    state <= RUN;
                    if (redirect_valid) begin
                        pc <= redirect_tgt;
                    end
                end
                RUN, FLUSH: begin
                    if (redirect_valid) begin
                        pc       <= redirect_tgt;
                        drop_cnt <= outstanding_nx;
                        state    <= (outstanding_nx != '0) ? FLUSH : RUN;
                    end else if (state == RUN) begin
                        if (req_fire) begin
                            pc <= pc + N'(PC_STEP);
                        end
                    end else begin
                        drop_cnt <= drop_nx;
                        if (drop_nx == '0) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_take),
        .flush     (1'b0),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .WIDTH (INSN_W + N),
        .DEPTH (DEPTH)
    ) u_buf_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (dec_pop),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> !tag_empty);
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == outstanding);
    a_tag_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(tag_full && req_fire && !rsp_take));
    a_buf_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(buf_full && rsp_push && !dec_pop));

endmodule
